lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Memory-side responder for the LC3 core's instruction and data memory interfaces: accepts fetch requests on `pc`/`instrmem_rd` and data requests on `Data_addr`/`Data_rd`, then returns `Instr_dout`/`Data_dout` with single-cycle `complete_instr`/`complete_data` pulses after a programmable latency. It sits opposite the LC3 pipeline as a synthesizable memory model with stall injection. It replaces behavioural memory in system-level runs.

## Interface
- `AW`, 12: word-address bits used; memory depth is 2^AW 16-bit words.
- `T_FETCH_LAT`, 0: wait cycles before an instruction response, 0..15.
- `T_DATA_LAT`, 0: wait cycles before a data response, 0..15.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on `clock`.
- `pc`  in  16  instruction fetch address.
- `instrmem_rd`  in  1  fetch request, held high by the core until `complete_instr`.
- `Instr_dout`  out  16  fetched instruction, valid while `complete_instr`=1.
- `complete_instr`  out  1  one-cycle fetch completion pulse.
- `data_en`  in  1  data request, held high until `complete_data`.
- `Data_rd`  in  1  1 = read, 0 = write; qualified by `data_en`.
- `Data_addr`  in  16  data address.
- `Data_din`  in  16  write data.
- `Data_dout`  out  16  read data, valid while `complete_data`=1.
- `complete_data`  out  1  one-cycle data completion pulse.

## Operation
- Memory index = address[AW-1:0]; upper bits ignored (aliasing wraps).
- Each port runs an independent FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: request high at an edge latches address, direction, write data, and latency L; next state is WAIT if L>0, otherwise RESP.
  - WAIT: counter is loaded with L-1 and decremented each cycle; it moves to RESP when it reaches 0.
  - RESP: complete=1 for exactly one cycle, then IDLE.
- Request inputs are ignored outside IDLE. A request still high in the cycle after RESP starts a new access.
- Read data is sampled from the array on the edge entering RESP. The `*_dout` register holds that value until the next response.
- Writes commit to the array on the edge entering RESP. `Data_dout` is unchanged for a write, but `complete_data` still pulses.
- If a fetch and a data write to the same index both enter RESP on the same edge, the fetch returns the old word (read-before-write).
- If two data accesses enter RESP on the same edge, they are serviced in port order.
- On reset (`reset`=0 at an edge):
  - FSMs go to IDLE; `complete_instr`, `complete_data` = 0; `Instr_dout`, `Data_dout` = 16'h0000.
  - Array contents are preserved.
  - An in-flight write is dropped.

## Timing
- Total request-to-complete latency is L+1 cycles from the sampling edge. With L=0, `complete` is high in the cycle immediately after the request is sampled.
- Minimum spacing between back-to-back accesses on one port is L+2 cycles.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- Reset is observed on the same edge it is sampled; outputs are 0 in the following cycle.

## Configuration
- `LC3_MEM_RAND_LAT_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 at reset and advances every cycle.
  - Per-access L = lfsr[3:0] mod (T_x_LAT+1), sampled at request acceptance. The instruction port uses lfsr[3:0] and the data port uses lfsr[7:4].
- Undefined: L = T_FETCH_LAT / T_DATA_LAT fixed, and no LFSR is present.

## Structure
- Package `lc3_mem_pkg`:
  - `port_state_t` enum (IDLE, WAIT, RESP).
  - LFSR seed (8'hA5) and tap mask.
  - Latency width constant (4).
- Sub-module `lc3_mem_port_fsm` holds the FSM, latency counter, and latched request. It is instantiated twice, for instruction and data.
- The top module owns the shared array, write/read arbitration, and the LFSR.
- Array preload uses a hierarchical backdoor by the bench; there are no load ports.

## Test plan
- **Reset:** drive `reset`=0 for 3 cycles with `instrmem_rd`=1 -> `complete_instr`=0 and `Instr_dout`=0 throughout; first completion occurs L+1 cycles after release.
- **Fetch, zero latency:** preload index 0x000 = 16'h1220, T_FETCH_LAT=0, `pc`=16'h3000 held high -> `complete_instr` every 2nd cycle with `Instr_dout`=16'h1220.
- **Write then read:** T_DATA_LAT=3, write 16'hBEEF to 16'h3005 -> `complete_data` 4 cycles after sampling; a later read of 16'h3005 returns 16'hBEEF after 4 cycles.
- **Same-edge collision:** T_FETCH_LAT=T_DATA_LAT=0, fetch and write to 16'h3010 (old 16'h0000, new 16'h5555) issued together -> `Instr_dout`=16'h0000; the next fetch returns 16'h5555.
- **Mid-access reset:** T_DATA_LAT=5, `reset`=0 in cycle 2 of a write to 16'h3020 (old 16'h1111) -> no `complete_data`; a later read returns 16'h1111.
- **Random latency (`LC3_MEM_RAND_LAT_EN`):** T_DATA_LAT=7, 100 reads -> every latency is in 0..7, and the sequence matches the reference LFSR model from seed 8'hA5.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder: port FSM states,
// latency width and the random-latency LFSR parameters.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } port_state_t;

    localparam int unsigned LatW = 4;

    localparam logic [7:0] LfsrSeed = 8'hA5;
    // Fibonacci taps 8,6,5,4 map onto state bits 7,5,4,3.
    localparam logic [7:0] LfsrTaps = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LfsrTaps)};
    endfunction

    function automatic logic [LatW-1:0] lat_mod(input logic [LatW-1:0] raw,
                                                input int unsigned max_lat);
        int unsigned r;
        r = 32'(raw) % (max_lat + 32'd1);
        return r[LatW-1:0];
    endfunction

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// One access port of the memory responder: IDLE -> WAIT -> RESP sequencing,
// latency countdown and the request captured at acceptance.
module lc3_mem_port_fsm
    import lc3_mem_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic [AW-1:0]   addr_i,
    input  logic            rd_i,
    input  logic [15:0]     wdata_i,
    input  logic [LatW-1:0] lat_i,
    output logic            fire_o,
    output logic [AW-1:0]   addr_o,
    output logic            rd_o,
    output logic [15:0]     wdata_o,
    output logic            complete_o
);

    port_state_t     state_q;
    logic [LatW-1:0] cnt_q;
    logic [AW-1:0]   addr_q;
    logic            rd_q;
    logic [15:0]     wdata_q;
    logic            complete_q;

    logic idle;
    assign idle = (state_q == StIdle);

    // fire_o marks the edge that enters RESP; with zero latency that is the
    // accepting edge itself, so the live request must be forwarded.
    assign fire_o  = (idle && req_i && (lat_i == '0)) ||
                     ((state_q == StWait) && (cnt_q == '0));
    assign addr_o  = idle ? addr_i  : addr_q;
    assign rd_o    = idle ? rd_i    : rd_q;
    assign wdata_o = idle ? wdata_i : wdata_q;

    assign complete_o = complete_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        rd_q    <= rd_i;
                        wdata_q <= wdata_i;
                        if (lat_i == '0) begin
                            state_q    <= StResp;
                            complete_q <= 1'b1;
                        end else begin
                            cnt_q   <= lat_i - 1'b1;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q    <= StResp;
                        complete_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Synthesizable LC3 instruction/data memory model with programmable stall latency.
// Define LC3_MEM_RAND_LAT_EN to draw per-access latency from an 8-bit LFSR.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter int unsigned T_FETCH_LAT = 0,
    parameter int unsigned T_DATA_LAT  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_en,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data
);

    logic [15:0] mem [2**AW];

    logic [LatW-1:0] i_lat;
    logic [LatW-1:0] d_lat;

`ifdef LC3_MEM_RAND_LAT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign i_lat = lat_mod(lfsr_q[3:0], T_FETCH_LAT);
    assign d_lat = lat_mod(lfsr_q[7:4], T_DATA_LAT);
`else
    assign i_lat = LatW'(T_FETCH_LAT);
    assign d_lat = LatW'(T_DATA_LAT);
`endif

    logic          i_fire;
    logic [AW-1:0] i_addr;
    logic          i_rd;
    logic [15:0]   i_wdata;

    logic          d_fire;
    logic [AW-1:0] d_addr;
    logic          d_rd;
    logic [15:0]   d_wdata;

    lc3_mem_port_fsm #(
        .AW (AW)
    ) u_instr_port (
        .clk_i      (clock),
        .rst_ni     (reset),
        .req_i      (instrmem_rd),
        .addr_i     (pc[AW-1:0]),
        .rd_i       (1'b1),
        .wdata_i    (16'h0000),
        .lat_i      (i_lat),
        .fire_o     (i_fire),
        .addr_o     (i_addr),
        .rd_o       (i_rd),
        .wdata_o    (i_wdata),
        .complete_o (complete_instr)
    );

    lc3_mem_port_fsm #(
        .AW (AW)
    ) u_data_port (
        .clk_i      (clock),
        .rst_ni     (reset),
        .req_i      (data_en),
        .addr_i     (Data_addr[AW-1:0]),
        .rd_i       (Data_rd),
        .wdata_i    (Data_din),
        .lat_i      (d_lat),
        .fire_o     (d_fire),
        .addr_o     (d_addr),
        .rd_o       (d_rd),
        .wdata_o    (d_wdata),
        .complete_o (complete_data)
    );

    // Address bits above AW alias; the fetch port never writes.
    logic unused_bits;
    assign unused_bits = ^{pc[15:AW], Data_addr[15:AW], i_rd, i_wdata};

    // A write in flight when reset is sampled never reaches the array.
    always_ff @(posedge clock) begin
        if (reset && d_fire && !d_rd) begin
            mem[d_addr] <= d_wdata;
        end
    end

    logic [15:0] instr_dout_q;
    logic [15:0] data_dout_q;

    // Reads use the pre-edge array, so a same-edge fetch sees the old word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            instr_dout_q <= 16'h0000;
            data_dout_q  <= 16'h0000;
        end else begin
            if (i_fire) begin
                instr_dout_q <= mem[i_addr];
            end
            if (d_fire && d_rd) begin
                data_dout_q <= mem[d_addr];
            end
        end
    end

    assign Instr_dout = instr_dout_q;
    assign Data_dout  = data_dout_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: cycle table plus reset and latency sequences.
module tb_lc3_mem_responder;

    localparam int unsigned TF = 0;
`ifdef LC3_MEM_RAND_LAT_EN
    localparam int unsigned TD = 7;
`else
    localparam int unsigned TD = 3;
`endif

    logic        clock;
    logic        reset;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        data_en;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;

    lc3_mem_responder #(
        .AW          (12),
        .T_FETCH_LAT (TF),
        .T_DATA_LAT  (TD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .data_en        (data_en),
        .Data_rd        (Data_rd),
        .Data_addr      (Data_addr),
        .Data_din       (Data_din),
        .Data_dout      (Data_dout),
        .complete_data  (complete_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for complete_data; lat is the number of wait cycles (edges after
    // the sampling edge minus one), or -1 on timeout.
    task automatic wait_cd(input string name, output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (complete_data) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) begin
            check({name, "_timeout"}, 16'h0, 16'h1);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic [15:0] pc;
        logic        den;
        logic        drd;
        logic [15:0] daddr;
        logic [15:0] ddin;
        logic        ci;
        logic [15:0] idout;
        logic        cd;
        logic [15:0] ddout;
    } vec_t;

    vec_t vecs[23];

`ifdef LC3_MEM_RAND_LAT_EN
    logic [7:0] m_lfsr;
    always @(posedge clock) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    initial begin
        int lat;
        int exp_lat;

        // Fetch at L=0 held high, write/read at L=3, alias fetch, same-edge collision.
        vecs[0]  = '{1'b1, 16'h3000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h1220, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 16'h3000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 16'h3000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h1220, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 16'h3000, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 16'h3000, 1'b1, 1'b0, 16'h3005, 16'hBEEF, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 16'h3000, 1'b1, 1'b0, 16'h3005, 16'hBEEF, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 16'h3000, 1'b1, 1'b0, 16'h3005, 16'hBEEF, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 16'h3000, 1'b1, 1'b0, 16'h3005, 16'hBEEF, 1'b0, 16'h1220, 1'b1, 16'h0000};
        vecs[8]  = '{1'b0, 16'h3000, 1'b0, 1'b0, 16'h3005, 16'hBEEF, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 16'h3000, 1'b1, 1'b1, 16'h3005, 16'h0000, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 16'h3000, 1'b1, 1'b1, 16'h3005, 16'h0000, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 16'h3000, 1'b1, 1'b1, 16'h3005, 16'h0000, 1'b0, 16'h1220, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 16'h3000, 1'b1, 1'b1, 16'h3005, 16'h0000, 1'b0, 16'h1220, 1'b1, 16'hBEEF};
        vecs[13] = '{1'b0, 16'h3000, 1'b0, 1'b1, 16'h3005, 16'h0000, 1'b0, 16'h1220, 1'b0, 16'hBEEF};
        vecs[14] = '{1'b1, 16'h7005, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[15] = '{1'b0, 16'h7005, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[16] = '{1'b0, 16'h3010, 1'b1, 1'b0, 16'h3010, 16'h5555, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[17] = '{1'b0, 16'h3010, 1'b1, 1'b0, 16'h3010, 16'h5555, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[18] = '{1'b0, 16'h3010, 1'b1, 1'b0, 16'h3010, 16'h5555, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF};
        vecs[19] = '{1'b1, 16'h3010, 1'b1, 1'b0, 16'h3010, 16'h5555, 1'b1, 16'h0000, 1'b1, 16'hBEEF};
        vecs[20] = '{1'b1, 16'h3010, 1'b0, 1'b0, 16'h3010, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'hBEEF};
        vecs[21] = '{1'b1, 16'h3010, 1'b0, 1'b0, 16'h3010, 16'h5555, 1'b1, 16'h5555, 1'b0, 16'hBEEF};
        vecs[22] = '{1'b0, 16'h3010, 1'b0, 1'b0, 16'h3010, 16'h5555, 1'b0, 16'h5555, 1'b0, 16'hBEEF};

        dut.mem[12'h000] = 16'h1220;
        dut.mem[12'h005] = 16'h0000;
        dut.mem[12'h010] = 16'h0000;
        dut.mem[12'h020] = 16'h1111;

        reset       = 1'b0;
        instrmem_rd = 1'b1;
        pc          = 16'h3000;
        data_en     = 1'b0;
        Data_rd     = 1'b1;
        Data_addr   = 16'h0000;
        Data_din    = 16'h0000;

        // Request held high through reset must not complete.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("reset_complete_instr", {15'h0, complete_instr}, 16'h0);
            check("reset_instr_dout", Instr_dout, 16'h0000);
            check("reset_complete_data", {15'h0, complete_data}, 16'h0);
            check("reset_data_dout", Data_dout, 16'h0000);
        end
        reset = 1'b1;

`ifdef LC3_MEM_RAND_LAT_EN
        @(negedge clock);
        check("rand_first_fetch_complete", {15'h0, complete_instr}, 16'h1);
        check("rand_first_fetch_dout", Instr_dout, 16'h1220);
        instrmem_rd = 1'b0;
        @(negedge clock);
        for (int r = 0; r < 100; r++) begin
            data_en   = 1'b1;
            Data_rd   = 1'b1;
            Data_addr = 16'h3000;
            exp_lat   = int'(m_lfsr[7:4]) % (TD + 1);
            wait_cd("rand_read", lat);
            check("rand_lat_range", 16'((lat >= 0 && lat <= 7) ? 1 : 0), 16'h1);
            check("rand_lat_model", 16'(lat), 16'(exp_lat));
            data_en = 1'b0;
            @(negedge clock);
        end
`else
        for (int i = 0; i < 23; i++) begin
            instrmem_rd = vecs[i].ireq;
            pc          = vecs[i].pc;
            data_en     = vecs[i].den;
            Data_rd     = vecs[i].drd;
            Data_addr   = vecs[i].daddr;
            Data_din    = vecs[i].ddin;
            @(negedge clock);
            check($sformatf("vec%0d_complete_instr", i), {15'h0, complete_instr},
                  {15'h0, vecs[i].ci});
            check($sformatf("vec%0d_instr_dout", i), Instr_dout, vecs[i].idout);
            check($sformatf("vec%0d_complete_data", i), {15'h0, complete_data},
                  {15'h0, vecs[i].cd});
            check($sformatf("vec%0d_data_dout", i), Data_dout, vecs[i].ddout);
        end

        // Reset lands in the second cycle of a write: the write must vanish.
        data_en   = 1'b1;
        Data_rd   = 1'b0;
        Data_addr = 16'h3020;
        Data_din  = 16'h2222;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_complete_data", {15'h0, complete_data}, 16'h0);
        check("midrst_data_dout", Data_dout, 16'h0000);
        check("midrst_instr_dout", Instr_dout, 16'h0000);
        reset   = 1'b1;
        data_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("midrst_no_complete", {15'h0, complete_data}, 16'h0);
        end

        data_en   = 1'b1;
        Data_rd   = 1'b1;
        Data_addr = 16'h3020;
        wait_cd("midrst_read", lat);
        check("midrst_read_latency", 16'(lat), 16'(TD));
        check("midrst_read_data", Data_dout, 16'h1111);
        data_en = 1'b0;
        @(negedge clock);
        check("midrst_read_pulse_end", {15'h0, complete_data}, 16'h0);
        check("midrst_read_hold", Data_dout, 16'h1111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
